maj_sweep_ctrl: RTL and testbench
=================================

MAJ_SWEEP_CTRL -- requirements
Module: maj_sweep_ctrl

Interface
REQ-001 SHALL have parameter HOLD, default 2: cycles each vector is held on maj_in before sampling; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a run; sampled only in IDLE.
REQ-005 SHALL have port single  input  1  sampled with start: 1 = apply one vector (vec), 0 = exhaustive sweep 0..7.
REQ-006 SHALL have port vec  input  3  vector for single mode, sampled with start.
REQ-007 SHALL have port maj_in  output  3  vector driven to the external 3-input majority unit.
REQ-008 SHALL have port maj_f  input  1  result returned by the majority unit.
REQ-009 SHALL have port busy  output  1  high in any state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-011 SHALL have port table  output  8  captured truth table; bit i = maj_f observed for maj_in = i.
REQ-012 SHALL have port err_cnt  output  4  mismatches versus golden majority in the last run.
REQ-013 SHALL have port pass  output  1  high when the last completed run had err_cnt == 0.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-015 IDLE with start=1 SHALL: go to DRIVE; load idx = single ? vec : 0; latch mode; clear err_cnt; clear table only in sweep mode.
REQ-016 DRIVE SHALL hold maj_in = idx for exactly HOLD cycles (hold counter), then go to SAMPLE.
REQ-017 SAMPLE SHALL write maj_f into table[idx] and compare it with golden bit TT_GOLDEN[idx]; on mismatch, err_cnt increments, saturating at 15.
REQ-018 SAMPLE SHALL go to DONE if single mode or idx == 7; otherwise idx increments and FSM returns to DRIVE. idx SHALL never wrap past 7.
REQ-019 DONE SHALL assert done for one cycle, update pass = (err_cnt_next == 0), then return to IDLE.
REQ-020 Sweep latency: done SHALL be high in the cycle after 8*(HOLD+1) rising edges following the edge that samples start (24 for HOLD=2). Single-mode latency SHALL be HOLD+1 edges.
REQ-021 start SHALL be ignored while busy; no queuing.
REQ-022 Back-to-back runs: start high in the IDLE cycle immediately after DONE SHALL be accepted.
REQ-023 maj_in SHALL be registered and SHALL keep its last value in IDLE.
REQ-024 table, err_cnt and pass SHALL remain stable outside SAMPLE/DONE updates.

Reset
REQ-025 rst SHALL force IDLE, maj_in=0, busy=0, done=0, table=8'h00, err_cnt=0, pass=0, idx=0, hold counter=0.
REQ-026 rst asserted mid-run SHALL abort on the next edge without a done pulse; rst has priority over start.

Structure
REQ-027 Package maj_ctrl_pkg SHALL hold the state enum, TT_GOLDEN = 8'hE8 (majority of 3), and the err_cnt width constant.
REQ-028 The hold counter SHALL be a sub-module maj_hold_timer (load/count/expire); everything else stays in maj_sweep_ctrl.

Verification
REQ-029 Correct majority model, HOLD=2, sweep: start -> maj_in steps 0..7, each held 2 cycles; done at edge 24; table=8'hE8; err_cnt=0; pass=1.
REQ-030 Model stuck-at-0, sweep -> table=8'h00, err_cnt=4, pass=0.
REQ-031 Inverted model (f = ~maj), sweep -> table=8'h17, err_cnt=8, pass=0.
REQ-032 Prior table=8'hE8, single=1, vec=3'b101, model correct -> done after 3 edges, table unchanged 8'hE8, err_cnt=0, pass=1.
REQ-033 start pulsed again at vector 3 of a sweep -> ignored; exactly one done pulse, at edge 24.
REQ-034 rst asserted while maj_in=4 -> next cycle busy=0, table=00, err_cnt=0, pass=0, no done pulse; a fresh sweep then completes normally.

Source files
------------

// File: rtl/maj_ctrl_pkg.sv
// Shared types and constants for the majority-unit sweep controller.
package maj_ctrl_pkg;

    localparam int unsigned VEC_W  = 3;
    localparam int unsigned TT_W   = 8;
    localparam int unsigned ERR_W  = 4;
    localparam int unsigned HOLD_W = 4;

    localparam logic [TT_W-1:0]  TT_GOLDEN = 8'hE8;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam logic [VEC_W-1:0] VEC_LAST  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    // Saturating increment for the mismatch counter.
    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/maj_hold_timer.sv
// Down-counter that keeps a vector on maj_in for HOLD cycles before sampling.
module maj_hold_timer
    import maj_ctrl_pkg::*;
#(
    parameter int unsigned HOLD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic count_i,
    output logic expire_c
);

    localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(HOLD - 1);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry in a DRIVE cycle means this is the last of the HOLD cycles.
    assign expire_c = (cnt_q == '0);

endmodule

// File: rtl/maj_sweep_ctrl.sv
// Drives vectors into an external 3-input majority unit, captures its truth
// table and counts mismatches against the golden majority function.
module maj_sweep_ctrl
    import maj_ctrl_pkg::*;
#(
    parameter int unsigned HOLD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             single,
    input  logic [VEC_W-1:0] vec,
    output logic [VEC_W-1:0] maj_in,
    input  logic             maj_f,
    output logic             busy,
    output logic             done,
    // Captured truth table ("table" itself is a reserved word).
    output logic [TT_W-1:0]  truth_table,
    output logic [ERR_W-1:0] err_cnt,
    output logic             pass
);

    state_e           state_q,   state_d;
    logic [VEC_W-1:0] idx_q,     idx_d;
    logic             single_q,  single_d;
    logic [VEC_W-1:0] maj_in_q,  maj_in_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [TT_W-1:0]  table_q,   table_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             pass_q,    pass_d;

    logic load_c;
    logic count_c;
    logic expire_c;

    maj_hold_timer #(
        .HOLD (HOLD)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_c),
        .count_i  (count_c),
        .expire_c (expire_c)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        single_d  = single_q;
        maj_in_d  = maj_in_q;
        table_d   = table_q;
        err_cnt_d = err_cnt_q;
        pass_d    = pass_q;
        load_c    = 1'b0;
        count_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_DRIVE;
                    idx_d     = single ? vec : '0;
                    maj_in_d  = single ? vec : '0;
                    single_d  = single;
                    err_cnt_d = '0;
                    load_c    = 1'b1;
                    // A single-vector run patches one bit of the previous table.
                    if (!single) begin
                        table_d = '0;
                    end
                end
            end
            ST_DRIVE: begin
                if (expire_c) begin
                    state_d = ST_SAMPLE;
                end else begin
                    count_c = 1'b1;
                end
            end
            ST_SAMPLE: begin
                table_d[idx_q] = maj_f;
                if (maj_f != TT_GOLDEN[idx_q]) begin
                    err_cnt_d = err_sat_inc(err_cnt_q);
                end
                if (single_q || (idx_q == VEC_LAST)) begin
                    state_d = ST_DONE;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    state_d  = ST_DRIVE;
                    idx_d    = idx_q + VEC_W'(1);
                    maj_in_d = idx_q + VEC_W'(1);
                    load_c   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            single_q  <= 1'b0;
            maj_in_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            table_q   <= '0;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            single_q  <= single_d;
            maj_in_q  <= maj_in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            table_q   <= table_d;
            err_cnt_q <= err_cnt_d;
            pass_q    <= pass_d;
        end
    end

    assign maj_in      = maj_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = table_q;
    assign err_cnt     = err_cnt_q;
    assign pass        = pass_q;

endmodule

// File: tb/tb_maj_sweep_ctrl.sv
// Self-checking bench for maj_sweep_ctrl with a switchable majority-unit model.
module tb_maj_sweep_ctrl;

    localparam int unsigned HOLD = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic       single;
    logic [2:0] vec;
    logic [2:0] maj_in;
    logic       maj_f;
    logic       busy;
    logic       done;
    logic [7:0] truth_table;
    logic [3:0] err_cnt;
    logic       pass;

    int unsigned n_checks;
    int unsigned n_errors;

    // 0 correct, 1 stuck-at-0, 2 inverted, 3 arbitrary table rnd_tt
    int          model;
    logic [7:0]  rnd_tt;
    logic [7:0]  ref_table;

    maj_sweep_ctrl #(
        .HOLD (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .single      (single),
        .vec         (vec),
        .maj_in      (maj_in),
        .maj_f       (maj_f),
        .busy        (busy),
        .done        (done),
        .truth_table (truth_table),
        .err_cnt     (err_cnt),
        .pass        (pass)
    );

    always #5 clk = ~clk;

    function automatic logic golden_maj(input int unsigned i);
        logic [2:0] b;
        b = 3'(i);
        return ($countones(b) >= 2);
    endfunction

    function automatic logic model_f(input int m, input int unsigned i, input logic [7:0] tt);
        case (m)
            0:       return golden_maj(i);
            1:       return 1'b0;
            2:       return !golden_maj(i);
            default: return tt[3'(i)];
        endcase
    endfunction

    always_comb maj_f = model_f(model, 32'(maj_in), rnd_tt);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One run: called #1 after an edge with the DUT idle; returns #1 after the
    // edge that brings it back to IDLE so calls chain back-to-back.
    task automatic run(input bit sgl, input logic [2:0] v, input int m, input bit poke);
        int unsigned lat;
        logic [7:0]  exp_table;
        int unsigned exp_err;
        logic [2:0]  exp_last;

        model     = m;
        exp_table = sgl ? ref_table : 8'h00;
        exp_err   = 0;
        for (int i = 0; i < 8; i++) begin
            if (!sgl || (i == int'(v))) begin
                exp_table[i] = model_f(m, 32'(i), rnd_tt);
                if (exp_table[i] != golden_maj(32'(i))) exp_err++;
            end
        end
        if (exp_err > 15) exp_err = 15;
        exp_last = sgl ? v : 3'd7;
        lat      = sgl ? HOLD + 1 : 8 * (HOLD + 1);

        start  = 1'b1;
        single = sgl;
        vec    = v;
        @(posedge clk); #1;
        start  = 1'b0;
        for (int unsigned k = 0; k < lat; k++) begin
            check_eq("busy_run", 32'(busy), 32'(1));
            check_eq("done_early", 32'(done), 32'(0));
            check_eq("maj_in_seq", 32'(maj_in), sgl ? 32'(v) : 32'(k / (HOLD + 1)));
            if (poke && (k == 3 * (HOLD + 1))) begin
                start  = 1'b1;
                single = 1'($urandom);
                vec    = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_eq("done_at_lat", 32'(done), 32'(1));
        check_eq("table", 32'(truth_table), 32'(exp_table));
        check_eq("err_cnt", 32'(err_cnt), exp_err);
        check_eq("pass", 32'(pass), 32'(exp_err == 0));
        @(posedge clk); #1;
        check_eq("done_pulse_end", 32'(done), 32'(0));
        check_eq("busy_idle", 32'(busy), 32'(0));
        check_eq("maj_in_hold", 32'(maj_in), 32'(exp_last));
        check_eq("table_stable", 32'(truth_table), 32'(exp_table));
        check_eq("pass_stable", 32'(pass), 32'(exp_err == 0));
        ref_table = exp_table;
    endtask

    initial begin
        bit saw_done;
        int guard;

        clk       = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        single    = 1'b0;
        vec       = 3'd0;
        model     = 0;
        rnd_tt    = 8'h00;
        ref_table = 8'h00;
        n_checks  = 0;
        n_errors  = 0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_done", 32'(done), 32'(0));
        check_eq("rst_maj_in", 32'(maj_in), 32'(0));
        check_eq("rst_table", 32'(truth_table), 32'(0));
        check_eq("rst_err", 32'(err_cnt), 32'(0));
        check_eq("rst_pass", 32'(pass), 32'(0));
        rst = 1'b0;

        run(1'b0, 3'd0, 0, 1'b0);
        run(1'b0, 3'd0, 1, 1'b0);
        run(1'b0, 3'd0, 2, 1'b0);
        run(1'b0, 3'd0, 0, 1'b0);
        run(1'b1, 3'b101, 0, 1'b0);
        run(1'b1, 3'b111, 1, 1'b0);
        run(1'b0, 3'd0, 0, 1'b1);

        // Abort mid-sweep with reset while vector 4 is on the bus.
        model  = 0;
        start  = 1'b1;
        single = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while ((maj_in != 3'd4) && (guard < 60)) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("abort_reach_vec4", 32'(maj_in), 32'(4));
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'(0));
        check_eq("abort_done", 32'(done), 32'(0));
        check_eq("abort_table", 32'(truth_table), 32'(0));
        check_eq("abort_err", 32'(err_cnt), 32'(0));
        check_eq("abort_pass", 32'(pass), 32'(0));
        check_eq("abort_maj_in", 32'(maj_in), 32'(0));
        saw_done = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            saw_done = saw_done | done;
        end
        check_eq("abort_no_done", 32'(saw_done), 32'(0));
        ref_table = 8'h00;
        run(1'b0, 3'd0, 0, 1'b0);

        for (int r = 0; r < 24; r++) begin
            rnd_tt = 8'($urandom);
            run(1'($urandom), 3'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
